// File: rtl/mmio_sram_if.sv
// mmio_sram bus bundle: request fields from the core, response and
// window-decode hit back from the RAM.
interface mmio_sram_if;
   logic [31:0] address;
   logic        req;
   logic        we;
   logic [3:0]  wstrb;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic        err;
   logic        selected;

   modport master (
      output address, req, we, wstrb, write_data,
      input  read_data, ready, err, selected
   );

   modport slave (
      input  address, req, we, wstrb, write_data,
      output read_data, ready, err, selected
   );
endinterface

// File: rtl/mmio_sram.sv
// mmio_sram: MMIO word RAM with byte-lane writes, wait states and a
// hardware zero-clear sweep after every reset.
module mmio_sram #(
   parameter logic [31:0] MMIO_BASE   = 32'h9000_0000,
   parameter int          ADDR_BITS   = 8,
   parameter int          WAIT_STATES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   mmio_sram_if.slave bus,
   output logic       init_done
);

   localparam int          AW    = ADDR_BITS - 2;
   localparam int          DEPTH = 1 << AW;
   localparam logic [31:0] MASK  = 32'((1 << ADDR_BITS) - 1);
   localparam logic [2:0]  WLAST =
      3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] ptr;
   logic [AW-1:0] idx;
   logic [2:0]    wcnt;
   logic [31:0]   rsp_q;
   logic          err_pend;
   logic          acc;
   logic          strb_ok;
   logic [31:0]   wmask;
   logic [31:0]   mem [DEPTH];

   assign idx          = bus.address[ADDR_BITS-1:2];
   assign bus.selected = (bus.address & ~MASK) == MMIO_BASE;
   assign bus.ready    = (state == RESP);
   assign bus.read_data = bus.ready ? rsp_q : '0;
   assign bus.err      = bus.ready & err_pend;

   // Only single bytes, aligned halves and the full word are legal strobes.
   always_comb begin
      strb_ok = 1'b0;
      case (bus.wstrb)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: strb_ok = 1'b1;
         default:                   strb_ok = 1'b0;
      endcase
   end

   // Expand byte strobes into a bit mask for the read-modify-write merge.
   always_comb begin
      wmask = '0;
      for (int i = 0; i < 4; i++) begin
         wmask[8*i +: 8] = {8{bus.wstrb[i]}};
      end
   end

   // Next-state logic; acc marks the accept edge of a transaction.
   always_comb begin
      state_nxt = state;
      acc       = 1'b0;
      unique case (state)
         INIT: if (ptr == '1) state_nxt = IDLE;
         IDLE: begin
            if (bus.req && bus.selected) begin
               acc       = 1'b1;
               state_nxt = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: if (wcnt == WLAST) state_nxt = RESP;
         RESP: state_nxt = IDLE;
      endcase
   end

   // Control registers: state, sweep pointer, wait counter, response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= INIT;
         ptr       <= '0;
         wcnt      <= '0;
         rsp_q     <= '0;
         err_pend  <= 1'b0;
         init_done <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == INIT) begin
            ptr <= ptr + AW'(1);
            if (ptr == '1) init_done <= 1'b1;
         end
         if (acc) wcnt <= '0;
         else if (state == WAIT) wcnt <= wcnt + 3'd1;
         if (acc) begin
            rsp_q    <= bus.we ? '0 : mem[idx];
            err_pend <= bus.we && !strb_ok;
         end else if (state == RESP) begin
            err_pend <= 1'b0;
         end
      end
   end

   // Storage array: no reset, it is cleared by the INIT sweep instead.
   always_ff @(posedge clk) begin
      if (state == INIT) begin
         mem[ptr] <= '0;
      end else if (acc && bus.we && strb_ok) begin
         mem[idx] <= (mem[idx] & ~wmask) | (bus.write_data & wmask);
      end
   end

endmodule

// File: tb/tb_mmio_sram.sv
// tb_mmio_sram: directed vector table plus hand sequences for the
// sweep, stall, throughput and reset corner cases of mmio_sram.
module tb_mmio_sram;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic init_done;
   int   n_cmp = 0;
   int   n_bad = 0;

   mmio_sram_if bus ();

   mmio_sram dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .init_done (init_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt [16];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] rd, output logic er,
                      output int lat, output logic early);
      rd = '0;
      er = 1'b0;
      lat = 0;
      early = 1'b0;
      @(negedge clk);
      bus.address = a;
      bus.we = w;
      bus.wstrb = s;
      bus.write_data = d;
      bus.req = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready) begin
            lat = i;
            rd = bus.read_data;
            er = bus.err;
            break;
         end
         if (bus.read_data !== '0 || bus.err !== 1'b0) early = 1'b1;
      end
      bus.req = 1'b0;
   endtask

   task automatic wait_init(output int n, output logic spur);
      n = 0;
      spur = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready) spur = 1'b1;
         if (init_done) begin
            n = i;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic        early;
      logic        spur;
      int          lat;
      int          n_init;
      int          n_rdy;
      logic [8:0]  pat;
      logic [31:0] b2b_rd;

      vt = '{
         '{1'b1, 32'h9000_0004, 4'b1111, 32'hDEAD_BEEF, 32'h0, 1'b0},
         '{1'b0, 32'h9000_0004, 4'b0000, 32'h0, 32'hDEAD_BEEF, 1'b0},
         '{1'b1, 32'h9000_0004, 4'b0010, 32'h0000_AA00, 32'h0, 1'b0},
         '{1'b0, 32'h9000_0004, 4'b0000, 32'h0, 32'hDEAD_AAEF, 1'b0},
         '{1'b1, 32'h9000_0004, 4'b1100, 32'h1234_0000, 32'h0, 1'b0},
         '{1'b0, 32'h9000_0004, 4'b0000, 32'h0, 32'h1234_AAEF, 1'b0},
         '{1'b1, 32'h9000_0004, 4'b0101, 32'hFFFF_FFFF, 32'h0, 1'b1},
         '{1'b0, 32'h9000_0004, 4'b0000, 32'h0, 32'h1234_AAEF, 1'b0},
         '{1'b1, 32'h9000_0004, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b1},
         '{1'b0, 32'h9000_0007, 4'b0000, 32'h0, 32'h1234_AAEF, 1'b0},
         '{1'b1, 32'h9000_00FC, 4'b0001, 32'hFFFF_FF55, 32'h0, 1'b0},
         '{1'b0, 32'h9000_00FC, 4'b0000, 32'h0, 32'h0000_0055, 1'b0},
         '{1'b1, 32'h9000_0000, 4'b1000, 32'hAB77_7777, 32'h0, 1'b0},
         '{1'b1, 32'h9000_0000, 4'b0011, 32'h9999_CDEF, 32'h0, 1'b0},
         '{1'b0, 32'h9000_0000, 4'b0000, 32'h0, 32'hAB00_CDEF, 1'b0},
         '{1'b0, 32'h9000_0008, 4'b0000, 32'h0, 32'h0000_0000, 1'b0}
      };

      bus.address = 32'h9000_0010;
      bus.we = 1'b0;
      bus.wstrb = 4'b0000;
      bus.write_data = '0;
      bus.req = 1'b1;

      // reset values, with a read already pending
      #12;
      chk("rst_ready", {31'b0, bus.ready}, 32'h0);
      chk("rst_err", {31'b0, bus.err}, 32'h0);
      chk("rst_rdata", bus.read_data, 32'h0);
      chk("rst_init_done", {31'b0, init_done}, 32'h0);
      chk("sel_in_init", {31'b0, bus.selected}, 32'h1);

      // sweep length and stalled request accepted first IDLE cycle
      @(negedge clk);
      rst_n = 1'b1;
      n_init = 0;
      n_rdy = 0;
      spur = 1'b0;
      rd = '1;
      er = 1'b1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         if (init_done && n_init == 0) n_init = i;
         if (bus.ready) begin
            n_rdy = i;
            rd = bus.read_data;
            er = bus.err;
            break;
         end
         if (bus.read_data !== '0) spur = 1'b1;
      end
      bus.req = 1'b0;
      chk("sweep_edges", n_init, 64);
      chk("stall_accept", n_rdy, 66);
      chk("cleared_rd", rd, 32'h0);
      chk("cleared_err", {31'b0, er}, 32'h0);
      chk("stall_rdata_idle", {31'b0, spur}, 32'h0);
      @(posedge clk);
      #1;

      // vector table
      for (int v = 0; v < 16; v++) begin
         txn(vt[v].we, vt[v].addr, vt[v].strb, vt[v].wdata, rd, er,
             lat, early);
         chk($sformatf("v%0d_rdata", v), rd, vt[v].exp_rd);
         chk($sformatf("v%0d_err", v), {31'b0, er},
             {31'b0, vt[v].exp_err});
         chk($sformatf("v%0d_lat", v), lat, 2);
         chk($sformatf("v%0d_pre", v), {31'b0, early}, 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_post", v),
             {bus.read_data[31:2], bus.ready, bus.err} |
             {bus.read_data[1:0], 30'b0}, 32'h0);
      end

      // req held through RESP: one response every 3 cycles
      @(negedge clk);
      bus.address = 32'h9000_0004;
      bus.we = 1'b0;
      bus.req = 1'b1;
      pat = '0;
      b2b_rd = '0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk);
         #1;
         pat[i] = bus.ready;
         if (i == 1) b2b_rd = bus.read_data;
      end
      bus.req = 1'b0;
      chk("b2b_pattern", {23'b0, pat}, 32'b010010010);
      chk("b2b_rdata", b2b_rd, 32'h1234_AAEF);
      @(posedge clk);
      #1;

      // window decode
      bus.address = 32'h9000_00FC;
      #1;
      chk("sel_top_word", {31'b0, bus.selected}, 32'h1);
      bus.address = 32'h9000_0100;
      #1;
      chk("sel_above", {31'b0, bus.selected}, 32'h0);
      bus.address = 32'h8FFF_FFFC;
      #1;
      chk("sel_below", {31'b0, bus.selected}, 32'h0);

      // decode miss ignored for 20 cycles
      @(negedge clk);
      bus.address = 32'h9100_0000;
      bus.we = 1'b0;
      bus.req = 1'b1;
      spur = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.ready || bus.read_data !== '0 || bus.selected)
            spur = 1'b1;
      end
      bus.req = 1'b0;
      chk("miss_ignored", {31'b0, spur}, 32'h0);

      // reset while the response is on the bus
      @(negedge clk);
      bus.address = 32'h9000_0004;
      bus.we = 1'b1;
      bus.wstrb = 4'b0101;
      bus.req = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("resp_err_before_rst", {30'b0, bus.ready, bus.err}, 32'h3);
      rst_n = 1'b0;
      #1;
      chk("resp_rst_drop",
          {bus.ready, bus.err, init_done, 29'b0} | bus.read_data, 32'h0);
      bus.req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(n_init, spur);
      chk("resweep1_edges", n_init, 64);

      txn(1'b1, 32'h9000_0004, 4'b1111, 32'hCAFE_F00D, rd, er, lat, early);
      @(posedge clk);
      #1;
      txn(1'b0, 32'h9000_0004, 4'b0000, 32'h0, rd, er, lat, early);
      chk("pre_rst_data", rd, 32'hCAFE_F00D);
      @(posedge clk);
      #1;

      // reset during WAIT: transaction dropped, memory cleared
      @(negedge clk);
      bus.address = 32'h9000_0004;
      bus.we = 1'b0;
      bus.req = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("wait_rst_drop",
          {bus.ready, bus.err, init_done, 29'b0} | bus.read_data, 32'h0);
      bus.req = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      wait_init(n_init, spur);
      chk("resweep2_edges", n_init, 64);
      chk("no_resp_after_rst", {31'b0, spur}, 32'h0);
      @(posedge clk);
      #1;
      txn(1'b0, 32'h9000_0004, 4'b0000, 32'h0, rd, er, lat, early);
      chk("cleared_after_rst", rd, 32'h0);
      chk("cleared_after_rst_lat", lat, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
